tms_wb_host_bridge: RTL and testbench

//  Byte-stream to Wishbone initiator (bus master).

---
 rtl/tms_wb_host_bridge.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_tms_wb_host_bridge.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tms_wb_host_bridge.sv
// -----------------------------------------------------------------------------
// tms_wb_host_bridge
//   Byte-stream to Wishbone classic initiator. Framed host commands arrive on an
//   8-bit valid/ready stream, are decoded into single 32-bit Wishbone cycles
//   toward the TMS1x00 register map (ROM adr[16], PLA adr[17], ctrl/debug
//   adr[23]), and a status byte (plus read data) is returned on an 8-bit
//   valid/ready output stream.
//
//   Frame: CMD byte, op = CMD[7:6]
//     00 WRITE : 3 address bytes then 4 data bytes, all LSB first
//     01 READ  : 3 address bytes, LSB first
//     10 PING  : no operands, no bus cycle, answers ST_OK
//     11 BAD   : no operands, no bus cycle, answers ST_BADCMD
//
// Ports
//   wb_clk_i, wb_rst_i      clock and synchronous active-high reset
//   in_data/valid/ready     command byte stream (bridge is the sink)
//   out_data/valid/ready    response byte stream (bridge is the source)
//   wbm_*                   Wishbone classic initiator port, sel fixed 4'hF
//   busy                    high whenever the FSM is not idle
//   err_sticky              set on bus timeout or bad opcode, cleared by reset
// -----------------------------------------------------------------------------
module tms_wb_host_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [7:0]  ST_OK          = 8'hA5,
  parameter logic [7:0]  ST_TIMEOUT     = 8'hEE,
  parameter logic [7:0]  ST_BADCMD      = 8'hE1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  output logic        busy,
  output logic        err_sticky
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_BUS  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam logic [1:0]  OP_WRITE  = 2'b00;
  localparam logic [1:0]  OP_READ   = 2'b01;
  localparam logic [1:0]  OP_PING   = 2'b10;
  localparam logic [1:0]  OP_BAD    = 2'b11;
  localparam logic [16:0] TMO_LIMIT = 17'(TIMEOUT_CYCLES);

  state_t      state_q,     state_d;
  logic [1:0]  op_q,        op_d;
  logic [1:0]  byte_cnt_q,  byte_cnt_d;
  logic [15:0] tmo_cnt_q,   tmo_cnt_d;
  logic [7:0]  status_q,    status_d;
  logic [31:0] rdata_q,     rdata_d;
  logic [2:0]  resp_left_q, resp_left_d;
  logic [23:0] adr_q,       adr_d;
  logic [31:0] wdat_q,      wdat_d;
  logic        cyc_q,       cyc_d;
  logic        we_q,        we_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q,  out_data_d;
  logic        in_ready_q,  in_ready_d;
  logic        busy_q,      busy_d;
  logic        err_q,       err_d;

  logic        in_fire_s;
  logic [16:0] tmo_next_s;

  assign in_fire_s  = in_valid && in_ready_q;
  assign tmo_next_s = {1'b0, tmo_cnt_q} + 17'd1;

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign wbm_adr_o  = {8'h00, adr_q};
  assign wbm_dat_o  = wdat_q;
  assign wbm_sel_o  = 4'hF;
  assign wbm_we_o   = we_q;
  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = cyc_q;
  assign busy       = busy_q;
  assign err_sticky = err_q;

  // Next-state and next-output computation for the whole bridge.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    byte_cnt_d  = byte_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    status_d    = status_q;
    rdata_d     = rdata_q;
    resp_left_d = resp_left_q;
    adr_d       = adr_q;
    wdat_d      = wdat_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (in_fire_s) begin
          op_d       = in_data[7:6];
          byte_cnt_d = 2'd0;
          case (in_data[7:6])
            OP_WRITE, OP_READ: begin
              state_d = S_ADDR;
            end
            OP_PING: begin
              status_d = ST_OK;
              state_d  = S_RESP;
            end
            OP_BAD: begin
              status_d = ST_BADCMD;
              err_d    = 1'b1;
              state_d  = S_RESP;
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ADDR: begin
        if (in_fire_s) begin
          // Shifting in from the top leaves the first (LSB) byte at [7:0]
          // after the third byte.
          adr_d = {in_data, adr_q[23:8]};
          if (byte_cnt_q == 2'd2) begin
            byte_cnt_d = 2'd0;
            if (op_q == OP_WRITE) begin
              state_d = S_DATA;
            end else begin
              state_d   = S_BUS;
              cyc_d     = 1'b1;
              we_d      = 1'b0;
              tmo_cnt_d = 16'd0;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else begin
          state_d = S_ADDR;
        end
      end

      S_DATA: begin
        if (in_fire_s) begin
          wdat_d = {in_data, wdat_q[31:8]};
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = 2'd0;
            state_d    = S_BUS;
            cyc_d      = 1'b1;
            we_d       = 1'b1;
            tmo_cnt_d  = 16'd0;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else begin
          state_d = S_DATA;
        end
      end

      S_BUS: begin
        // Ack wins over a timeout that would expire on the same edge.
        if (wbm_ack_i) begin
          if (!we_q) begin
            rdata_d = wbm_dat_i;
          end else begin
            rdata_d = rdata_q;
          end
          status_d  = ST_OK;
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          tmo_cnt_d = 16'd0;
          state_d   = S_RESP;
        end else if (tmo_next_s == TMO_LIMIT) begin
          status_d  = ST_TIMEOUT;
          err_d     = 1'b1;
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          tmo_cnt_d = 16'd0;
          state_d   = S_RESP;
        end else begin
          tmo_cnt_d = tmo_next_s[15:0];
        end
      end

      S_RESP: begin
        // First RESP cycle loads the status byte; later bytes replace the
        // current one only on a completed handshake.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = status_q;
          if ((op_q == OP_READ) && (status_q == ST_OK)) begin
            resp_left_d = 3'd4;
          end else begin
            resp_left_d = 3'd0;
          end
        end else if (out_ready) begin
          if (resp_left_q != 3'd0) begin
            out_data_d  = rdata_q[7:0];
            rdata_d     = {8'h00, rdata_q[31:8]};
            resp_left_d = resp_left_q - 3'd1;
          end else begin
            out_valid_d = 1'b0;
            out_data_d  = 8'h00;
            state_d     = S_IDLE;
          end
        end else begin
          out_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase

    in_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_DATA);
    busy_d     = (state_d != S_IDLE);
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      op_q        <= 2'd0;
      byte_cnt_q  <= 2'd0;
      tmo_cnt_q   <= 16'd0;
      status_q    <= 8'h00;
      rdata_q     <= 32'h0000_0000;
      resp_left_q <= 3'd0;
      adr_q       <= 24'h00_0000;
      wdat_q      <= 32'h0000_0000;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      byte_cnt_q  <= byte_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      status_q    <= status_d;
      rdata_q     <= rdata_d;
      resp_left_q <= resp_left_d;
      adr_q       <= adr_d;
      wdat_q      <= wdat_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_tms_wb_host_bridge.sv
module tb_tms_wb_host_bridge;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_ack_i;
  logic        busy;
  logic        err_sticky;

  always #5 clk = ~clk;

  tms_wb_host_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .wbm_adr_o  (wbm_adr_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_dat_i  (wbm_dat_i),
    .wbm_sel_o  (wbm_sel_o),
    .wbm_we_o   (wbm_we_o),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_ack_i  (wbm_ack_i),
    .busy       (busy),
    .err_sticky (err_sticky)
  );

  int total = 0;
  int bad   = 0;

  // Slave / monitor controls and observations
  bit          ack_en     = 1'b1;
  int          ack_delay  = 0;
  logic [31:0] slv_rdata  = 32'h0;
  bit          late_ack   = 1'b0;
  bit          rand_ready = 1'b0;
  bit          stall_arm  = 1'b0;
  int          stall_left = 0;
  int          ncnt = 0, wait_cnt = 0, stb_len = 0, last_stb_len = 0;
  int          bus_starts = 0, stable_err = 0, hold_err = 0;
  int          ack_k = 0, ov_k = 0;
  logic        stb_prev = 1'b0, ov_prev = 1'b0, ord_prev = 1'b0;
  logic [7:0]  od_prev = 8'h00;
  logic [31:0] cur_adr, cur_dat;
  logic        cur_we;
  logic [31:0] bus_adr_q[$];
  logic [31:0] bus_dat_q[$];
  logic        bus_we_q[$];
  logic [7:0]  got_q[$];
  logic        err_exp = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wishbone slave, output-stream sink and protocol monitor, all at negedge.
  initial begin
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      ncnt++;
      if (wbm_ack_i && stb_prev) ack_k = ncnt;
      if (out_valid && !ov_prev) ov_k = ncnt;
      if (wbm_stb_o && !stb_prev) begin
        bus_starts++;
        stb_len = 0;
        cur_adr = wbm_adr_o; cur_dat = wbm_dat_o; cur_we = wbm_we_o;
        bus_adr_q.push_back(wbm_adr_o);
        bus_dat_q.push_back(wbm_dat_o);
        bus_we_q.push_back(wbm_we_o);
      end
      if (wbm_stb_o) begin
        stb_len++;
        if (wbm_adr_o !== cur_adr || wbm_dat_o !== cur_dat || wbm_we_o !== cur_we ||
            wbm_cyc_o !== 1'b1 || wbm_sel_o !== 4'hF) stable_err++;
      end
      if (!wbm_stb_o && stb_prev) last_stb_len = stb_len;
      if (ov_prev && !ord_prev && !(out_valid === 1'b1 && out_data === od_prev)) hold_err++;

      if (late_ack) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = $urandom;
      end else if (wbm_stb_o && ack_en) begin
        wait_cnt++;
        if (wait_cnt > ack_delay && !wbm_ack_i) begin
          wbm_ack_i = 1'b1;
          wbm_dat_i = slv_rdata;
        end else begin
          wbm_ack_i = 1'b0;
          wbm_dat_i = $urandom;
        end
      end else begin
        wbm_ack_i = 1'b0;
        wbm_dat_i = $urandom;
        wait_cnt  = 0;
      end

      if (stall_arm && out_valid) begin
        stall_left = 10;
        stall_arm  = 1'b0;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (rand_ready) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) got_q.push_back(out_data);

      ov_prev  = out_valid;
      ord_prev = out_ready;
      od_prev  = out_data;
      stb_prev = wbm_stb_o;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=time_limit expected=finish");
    $fatal(1, "watchdog");
  end

  // Called at a negedge, returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      total++; bad++;
      $error("FAIL send_byte_wait observed=%0d expected=<300", n);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_resp(input int n);
    int c;
    c = 0;
    while ((got_q.size() < n || busy !== 1'b0) && c < 500) begin
      @(negedge clk);
      c++;
    end
    if (c >= 500) begin
      total++; bad++;
      $error("FAIL resp_wait observed=%0d bytes expected=%0d", got_q.size(), n);
    end
  endtask

  // One command against the reference model: expected bytes from the op rules.
  task automatic run_cmd(input logic [1:0] op, input logic [23:0] a, input logic [31:0] d,
                         input bit do_ack, input int dly, input logic [31:0] rd,
                         input string tag);
    logic [7:0] exp_q[$];
    int         starts0;
    bit         is_bus;
    ack_en    = do_ack;
    ack_delay = dly;
    slv_rdata = rd;
    got_q.delete();
    bus_adr_q.delete(); bus_dat_q.delete(); bus_we_q.delete();
    starts0 = bus_starts;
    is_bus  = (op == 2'b00) || (op == 2'b01);

    if (op == 2'b10)       exp_q.push_back(8'hA5);
    else if (op == 2'b11)  exp_q.push_back(8'hE1);
    else if (!do_ack)      exp_q.push_back(8'hEE);
    else begin
      exp_q.push_back(8'hA5);
      if (op == 2'b01) for (int i = 0; i < 4; i++) exp_q.push_back(rd[8*i +: 8]);
    end
    if (op == 2'b11 || (is_bus && !do_ack)) err_exp = 1'b1;

    send_byte({op, 6'($urandom)});
    if (is_bus) begin
      send_byte(a[7:0]); send_byte(a[15:8]); send_byte(a[23:16]);
      if (op == 2'b00) for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
      check({tag, "_stb_latency"}, 32'(wbm_stb_o), 32'd1);
    end
    wait_resp(exp_q.size());
    check({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check({tag, "_byte"}, (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hFFFF_FFFF, {24'h0, exp_q[i]});
    check({tag, "_bus_cycles"}, 32'(bus_starts - starts0), is_bus ? 32'd1 : 32'd0);
    if (is_bus && bus_adr_q.size() > 0) begin
      check({tag, "_adr"}, bus_adr_q[0], {8'h00, a});
      check({tag, "_we"}, 32'(bus_we_q[0]), (op == 2'b00) ? 32'd1 : 32'd0);
      if (op == 2'b00) check({tag, "_dat"}, bus_dat_q[0], d);
      if (do_ack) begin
        check({tag, "_stb_len"}, 32'(last_stb_len), 32'(dly + 1));
        check({tag, "_ack_to_valid"}, 32'(ov_k - ack_k), 32'd1);
      end else begin
        check({tag, "_tmo_stb_len"}, 32'(last_stb_len), 32'(TMO));
      end
    end
    check({tag, "_err_sticky"}, 32'(err_sticky), 32'(err_exp));
    check({tag, "_hold"}, 32'(hold_err), 32'd0);
    check({tag, "_stable"}, 32'(stable_err), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_sticky), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_cyc_stb_we", {29'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'd0);
    check("rst_adr", wbm_adr_o, 32'd0);
    check("rst_dat", wbm_dat_o, 32'd0);
    check("rst_sel", 32'(wbm_sel_o), 32'hF);
    rst = 1'b0;
    @(negedge clk);

    run_cmd(2'b00, 24'h01_0000, 32'h1234_5678, 1'b1, 2, 32'h0, "t1_write");
    run_cmd(2'b01, 24'h02_0000, 32'h0, 1'b1, 0, 32'hCAFE_F00D, "t2_read");
    run_cmd(2'b01, 24'h80_0000, 32'h0, 1'b0, 0, 32'h0, "t3_timeout");
    run_cmd(2'b10, 24'h0, 32'h0, 1'b1, 0, 32'h0, "t4_ping");
    run_cmd(2'b11, 24'h0, 32'h0, 1'b1, 0, 32'h0, "t4_bad");
    run_cmd(2'b00, 24'h80_0004, 32'hDEAD_BEEF, 1'b1, TMO - 1, 32'h0, "ack_at_limit");
    run_cmd(2'b01, 24'h80_0008, 32'h0, 1'b1, TMO - 1, 32'h1357_9BDF, "rd_ack_at_limit");

    stall_arm = 1'b1;
    run_cmd(2'b01, 24'h01_0040, 32'h0, 1'b1, 1, 32'h89AB_CDEF, "t5_backpressure");

    late_ack = 1'b1;
    repeat (4) @(negedge clk);
    check("late_ack_busy", 32'(busy), 32'd0);
    check("late_ack_stb", 32'(wbm_stb_o), 32'd0);
    check("late_ack_out_valid", 32'(out_valid), 32'd0);
    late_ack = 1'b0;
    @(negedge clk);
    run_cmd(2'b10, 24'h0, 32'h0, 1'b1, 0, 32'h0, "after_late_ack_ping");

    ack_en = 1'b0;
    send_byte(8'h40); send_byte(8'h10); send_byte(8'h00); send_byte(8'h02);
    check("t6_stb_before_rst", 32'(wbm_stb_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_cyc_stb_we", {29'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'd0);
    check("t6_adr", wbm_adr_o, 32'd0);
    check("t6_dat", wbm_dat_o, 32'd0);
    check("t6_out", {23'd0, out_valid, out_data}, 32'd0);
    check("t6_in_ready_busy_err", {29'd0, in_ready, busy, err_sticky}, 32'd4);
    rst     = 1'b0;
    err_exp = 1'b0;
    @(negedge clk);
    run_cmd(2'b10, 24'h0, 32'h0, 1'b1, 0, 32'h0, "t6_ping");

    rand_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      run_cmd(2'($urandom_range(0, 3)), 24'($urandom), $urandom,
              $urandom_range(0, 4) != 0, $urandom_range(0, TMO - 1), $urandom, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
